// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, result {remainder, quotient}.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle (16 iterations instead of 32).
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_div,
  input  logic        signed_div,
  input  logic [31:0] div_srca,
  input  logic [31:0] div_srcb,
  input  logic        annul,
  output logic        div_ready,
  output logic [63:0] div_result
);
  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;
`ifdef DIV_RADIX4_EN
  localparam logic [4:0] LAST = 5'd15;
`else
  localparam logic [4:0] LAST = 5'd31;
`endif
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d, result_q, result_d, fin;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic        accept;
  logic [32:0] a_ext, b_ext, a_mag, b_mag;

  // rq holds {partial remainder, dividend bits still being shifted out / quotient bits shifted in}
  function automatic logic [63:0] step(input logic [63:0] rq, input logic [31:0] d);
    logic [32:0] sh, df;
    sh = rq[63:31];
    df = sh - {1'b0, d};
    return df[32] ? {sh[31:0], rq[30:0], 1'b0} : {df[31:0], rq[30:0], 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rq_q     <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rq_q     <= rq_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_div ? (div_srcb == 32'd0 ? ZERO : BUSY) : IDLE;
      ZERO:    state_d = DONE;
      BUSY:    state_d = cnt_q == LAST ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
    if (annul) state_d = IDLE;
  end

  assign accept = state_q == IDLE && start_div && !annul;
  assign a_ext  = {signed_div & div_srca[31], div_srca};
  assign b_ext  = {signed_div & div_srcb[31], div_srcb};
  assign a_mag  = a_ext[32] ? -a_ext : a_ext;
  assign b_mag  = b_ext[32] ? -b_ext : b_ext;
`ifdef DIV_RADIX4_EN
  assign fin = step(step(rq_q, dvs_q), dvs_q);
`else
  assign fin = step(rq_q, dvs_q);
`endif

  always_comb begin
    cnt_d    = cnt_q;
    rq_d     = rq_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    if (accept) begin
      cnt_d   = '0;
      rq_d    = {32'd0, a_mag[31:0]};
      dvs_d   = b_mag[31:0];
      neg_q_d = a_ext[32] ^ b_ext[32];
      neg_r_d = a_ext[32];
    end
    if (state_q == BUSY && !annul) begin
      rq_d  = fin;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST)
        result_d = {neg_r_q ? -fin[63:32] : fin[63:32], neg_q_q ? -fin[31:0] : fin[31:0]};
    end
    if (state_q == ZERO && !annul) result_d = '0;
  end

  assign div_ready  = state_q == DONE && !annul;
  assign div_result = result_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the only build-time option is the macro in Configuration.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start_div  in  1  request; the execute stage holds it high until div_ready.
REQ-005 signed_div  in  1  1 = signed (two's complement), 0 = unsigned; sampled with start_div.
REQ-006 div_srca  in  32  dividend; sampled with start_div.
REQ-007 div_srcb  in  32  divisor; sampled with start_div.
REQ-008 annul  in  1  abort the in-flight operation; tie 0 if unused.
REQ-009 div_ready  out  1  one-cycle pulse: div_result is valid.
REQ-010 div_result  out  64  {remainder[63:32], quotient[31:0]}, registered (hi = remainder, lo = quotient).

Function
REQ-011 States SHALL be IDLE, ZERO, BUSY and DONE.
REQ-012 IDLE with start_div=1 SHALL latch the operands and signed_div in that cycle, T.
REQ-013 From IDLE, the next state SHALL be ZERO if div_srcb==0, else BUSY with the iteration counter cleared.
REQ-014 IDLE with start_div=0 SHALL stay in IDLE.
REQ-015 In signed mode the block SHALL divide operand magnitudes (abs computed in 33 bits, so 0x80000000 has magnitude 2^31).
REQ-016 Signed result rules:
- quotient SHALL be negated iff the operand signs differ;
- remainder SHALL take the dividend's sign;
- quotient truncates toward zero.
REQ-017 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, with no exception or flag.
REQ-018 BUSY SHALL perform one restoring shift-subtract step per cycle, 32 cycles in total.
REQ-019 After the last BUSY cycle the state SHALL be DONE; the sign fix-up is applied on the final iteration.
REQ-020 ZERO SHALL last one cycle, load div_result=64'h0 and go to DONE.
REQ-021 In DONE, div_ready=1 for exactly one cycle, with div_result valid that cycle; then IDLE.
REQ-022 start_div sampled in DONE SHALL be ignored.
REQ-023 Latency from acceptance in cycle T: div_ready at T+33 (normal) or T+2 (divide by zero).
REQ-024 div_result SHALL hold its last value until the next result is loaded; div_ready=0 outside DONE.
REQ-025 Back-to-back: a start_div asserted in the cycle after DONE SHALL be accepted (from IDLE).
REQ-026 annul=1 in ZERO, BUSY or DONE SHALL force IDLE next cycle, suppress div_ready and leave div_result unchanged.
REQ-027 annul=1 in IDLE SHALL block acceptance in that cycle.
REQ-028 rst SHALL take priority over annul and start_div.

Reset
REQ-029 rst=1 SHALL force, on the next edge: state=IDLE, div_ready=0, div_result=64'h0, counter=0, and all operand/working registers=0.
REQ-030 rst asserted mid-operation SHALL discard the operation; no div_ready for it follows.

Configuration
REQ-031 With DIV_RADIX4_EN defined, BUSY SHALL retire 2 quotient bits per cycle over 16 cycles, giving div_ready at T+17.
REQ-032 Without DIV_RADIX4_EN, the radix-2 32-cycle loop applies (div_ready at T+33).
REQ-033 Results, the divide-by-zero path and the handshake SHALL be identical in both builds.

Verification
REQ-034 Unsigned 100/7: srca=100, srcb=7, signed=0 -> div_ready at T+33, div_result={32'd2, 32'd14}.
REQ-035 Signed -7/2: srca=0xFFFFFFF9, srcb=2, signed=1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-036 srca=0x80000000, srcb=0xFFFFFFFF:
- signed -> {0x00000000, 0x80000000};
- unsigned -> {0x80000000, 0x00000000}.
REQ-037 srcb=0, any srca -> div_ready at T+2, div_result=64'h0, single-cycle pulse.
REQ-038 Back-to-back: first op 100/7; start_div low for one cycle after div_ready; then 9/3 unsigned -> second div_ready 33 cycles after re-acceptance, result {0, 3}.
REQ-039 Abort and reset mid-operation:
- annul at BUSY cycle 10 -> IDLE next cycle, no div_ready, div_result unchanged;
- repeat with rst instead -> div_result=0.
